// File: rtl/alu_multicycle_if.sv
// Operand/result handshake bundle between decode, the sequential ALU and write-back.
interface alu_multicycle_if #(
    parameter int WIDTH = 32,
    parameter int FUN_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] aluA;
    logic [WIDTH-1:0] aluB;
    logic [FUN_W-1:0] alufun;
    logic             set_cc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] valE;
    logic             err;
    logic             cc_zf;
    logic             cc_sf;
    logic             cc_of;

    modport master (
        output in_valid, aluA, aluB, alufun, set_cc, out_ready,
        input  in_ready, out_valid, valE, err, cc_zf, cc_sf, cc_of
    );

    modport slave (
        input  in_valid, aluA, aluB, alufun, set_cc, out_ready,
        output in_ready, out_valid, valE, err, cc_zf, cc_sf, cc_of
    );
endinterface

// File: rtl/alu_multicycle.sv
// Sequential execute-stage ALU: ADD/SUB/AND/XOR in one cycle, shift-add MUL in WIDTH+1.
// One operation in flight; result and flags held in DONE until out_ready.
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int FUN_W = 4
) (
    input logic               clk,
    input logic               rst_n,
    alu_multicycle_if.slave   bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [FUN_W-1:0] FUN_ADD = FUN_W'(0);
    localparam logic [FUN_W-1:0] FUN_SUB = FUN_W'(1);
    localparam logic [FUN_W-1:0] FUN_AND = FUN_W'(2);
    localparam logic [FUN_W-1:0] FUN_XOR = FUN_W'(3);
    localparam logic [FUN_W-1:0] FUN_MUL = FUN_W'(4);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, stateNext;
    logic             accept;
    logic             mulLast;
    logic [WIDTH-1:0] mulAcc, mulCand, mulPlier, mulSum;
    logic [CNT_W-1:0] mulCnt;
    logic             opSetCc;
    logic [WIDTH-1:0] opRes;
    logic             opOf;
    logic             opIllegal;
    logic [WIDTH-1:0] resReg;
    logic             errReg, zfReg, sfReg, ofReg;

    assign mulLast       = (mulCnt == CNT_W'(WIDTH - 1));
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.valE      = resReg;
    assign bus.err       = errReg;
    assign bus.cc_zf     = zfReg;
    assign bus.cc_sf     = sfReg;
    assign bus.cc_of     = ofReg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        case (state)
            IDLE: if (bus.in_valid) begin
                accept    = 1'b1;
                stateNext = (bus.alufun == FUN_MUL) ? BUSY : DONE;
            end
            BUSY:    if (mulLast) stateNext = DONE;
            DONE:    if (bus.out_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Single-cycle ops are evaluated straight off the operand bus at accept.
    always_comb begin
        opRes     = '0;
        opOf      = 1'b0;
        opIllegal = 1'b0;
        case (bus.alufun)
            FUN_ADD: begin
                opRes = bus.aluA + bus.aluB;
                opOf  = (bus.aluA[WIDTH-1] == bus.aluB[WIDTH-1]) &&
                        (opRes[WIDTH-1] != bus.aluA[WIDTH-1]);
            end
            FUN_SUB: begin
                opRes = bus.aluA - bus.aluB;
                opOf  = (bus.aluA[WIDTH-1] != bus.aluB[WIDTH-1]) &&
                        (opRes[WIDTH-1] != bus.aluA[WIDTH-1]);
            end
            FUN_AND: opRes = bus.aluA & bus.aluB;
            FUN_XOR: opRes = bus.aluA ^ bus.aluB;
            FUN_MUL: opRes = '0;
            default: opIllegal = 1'b1;
        endcase
        mulSum = mulAcc + (mulPlier[0] ? mulCand : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resReg   <= '0;
            errReg   <= 1'b0;
            zfReg    <= 1'b1;
            sfReg    <= 1'b0;
            ofReg    <= 1'b0;
            opSetCc  <= 1'b0;
            mulAcc   <= '0;
            mulCand  <= '0;
            mulPlier <= '0;
            mulCnt   <= '0;
        end else if (accept) begin
            opSetCc  <= bus.set_cc;
            mulAcc   <= '0;
            mulCand  <= bus.aluA;
            mulPlier <= bus.aluB;
            mulCnt   <= '0;
            if (bus.alufun != FUN_MUL) begin
                resReg <= opRes;
                errReg <= opIllegal;
                if (bus.set_cc && !opIllegal) begin
                    zfReg <= (opRes == '0);
                    sfReg <= opRes[WIDTH-1];
                    ofReg <= opOf;
                end
            end else begin
                errReg <= 1'b0;
            end
        end else if (state == BUSY) begin
            // Multiplicand walks left while the multiplier bit under test walks right.
            mulAcc   <= mulSum;
            mulCand  <= mulCand << 1;
            mulPlier <= mulPlier >> 1;
            mulCnt   <= mulCnt + 1'b1;
            if (mulLast) begin
                resReg <= mulSum;
                if (opSetCc) begin
                    zfReg <= (mulSum == '0);
                    sfReg <= mulSum[WIDTH-1];
                    ofReg <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// Randomised and directed bench for alu_multicycle against an arithmetic reference model.
module tb_alu_multicycle;
    localparam int WIDTH = 32;
    localparam int FUN_W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errCnt = 0;
    int   chkCnt = 0;

    // Reference condition-code state.
    logic expZ = 1'b1, expS = 1'b0, expO = 1'b0;

    always #5 clk = ~clk;

    alu_multicycle_if #(.WIDTH(WIDTH), .FUN_W(FUN_W)) bus ();

    alu_multicycle #(.WIDTH(WIDTH), .FUN_W(FUN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Result and overflow from signed/unsigned integer arithmetic.
    function automatic void refOp(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f,
                                  output logic [31:0] r, output logic e, output logic o);
        longint sa, sb, s, maxS, minS;
        logic [63:0] p;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        maxS = (longint'(1) <<< (WIDTH - 1)) - 1;
        minS = -(longint'(1) <<< (WIDTH - 1));
        r = '0; e = 1'b0; o = 1'b0;
        case (f)
            4'd0: begin s = sa + sb; r = a + b; o = (s > maxS) || (s < minS); end
            4'd1: begin s = sa - sb; r = a - b; o = (s > maxS) || (s < minS); end
            4'd2: r = a & b;
            4'd3: r = a ^ b;
            4'd4: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
            default: e = 1'b1;
        endcase
    endfunction

    task automatic doOp(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f,
                        input logic sc, input int hold, input string tag);
        logic [31:0] expR, held;
        logic        expE, expOf, rdyBad, holdBad;
        int          lat, waitCnt, expLat;
        refOp(a, b, f, expR, expE, expOf);
        expLat = (f == 4'd4) ? WIDTH + 1 : 1;
        @(negedge clk);
        bus.aluA = a; bus.aluB = b; bus.alufun = f; bus.set_cc = sc; bus.in_valid = 1'b1;
        waitCnt = 0;
        while (!bus.in_ready && waitCnt < 100) begin @(negedge clk); waitCnt++; end
        checkVal($sformatf("%s_accRdy", tag), bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1; rdyBad = 1'b0;
        while (!bus.out_valid && lat < 200) begin
            if (bus.in_ready) rdyBad = 1'b1;
            @(negedge clk);
            lat++;
        end
        checkVal($sformatf("%s_busyRdy", tag), rdyBad, 0);
        checkVal($sformatf("%s_outVld", tag), bus.out_valid, 1);
        checkVal($sformatf("%s_lat", tag), lat, expLat);
        if (sc && !expE) begin
            expZ = (expR == 0); expS = expR[31]; expO = expOf;
        end
        checkVal($sformatf("%s_valE", tag), bus.valE, expR);
        checkVal($sformatf("%s_err", tag), bus.err, expE);
        checkVal($sformatf("%s_zf", tag), bus.cc_zf, expZ);
        checkVal($sformatf("%s_sf", tag), bus.cc_sf, expS);
        checkVal($sformatf("%s_of", tag), bus.cc_of, expO);
        held = bus.valE; holdBad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            // Offer a competing operation that must be ignored while the result waits.
            bus.in_valid = 1'b1; bus.alufun = 4'd0; bus.aluA = $urandom; bus.aluB = $urandom;
            @(negedge clk);
            if (bus.valE !== held || !bus.out_valid || bus.in_ready) holdBad = 1'b1;
        end
        if (hold > 0) checkVal($sformatf("%s_hold", tag), holdBad, 0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkVal($sformatf("%s_drain", tag), {bus.out_valid, bus.in_ready}, 2'b01);
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 4))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.set_cc = 1'b0;
        bus.aluA = '0; bus.aluB = '0; bus.alufun = '0;
        repeat (3) @(negedge clk);
        checkVal("rst_outVld", bus.out_valid, 0);
        checkVal("rst_valE", bus.valE, 0);
        checkVal("rst_err", bus.err, 0);
        checkVal("rst_cc", {bus.cc_zf, bus.cc_sf, bus.cc_of}, 3'b100);
        rst_n = 1'b1;
        @(negedge clk);
        checkVal("rst_inRdy", bus.in_ready, 1);

        doOp(32'hBE, 32'hAA, 4'd0, 1'b1, 0, "add1");
        doOp(32'h8000_0000, 32'd1, 4'd1, 1'b1, 0, "subOf");
        doOp(32'd5, 32'd5, 4'd1, 1'b1, 0, "subZero");
        doOp(32'd1, 32'd2, 4'd7, 1'b1, 0, "illegal7");
        doOp(32'h1234, 32'h10, 4'd4, 1'b1, 0, "mul1");
        doOp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd4, 1'b1, 0, "mulNeg");
        doOp(32'hF0F0, 32'hFF00, 4'd3, 1'b1, 5, "xorHold");
        doOp(32'h7FFF_FFFF, 32'd1, 4'd0, 1'b1, 0, "addOf");
        doOp(32'hFFFF_0000, 32'h00FF_FF00, 4'd2, 1'b0, 1, "andNoCc");

        for (int i = 0; i < 40; i++)
            doOp(pickOperand(), pickOperand(), 4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), $sformatf("rnd%0d", i));

        // Abort a multiply part-way through with reset.
        @(negedge clk);
        bus.aluA = 32'h1234; bus.aluB = 32'h10; bus.alufun = 4'd4; bus.set_cc = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkVal("midRst_outVld", bus.out_valid, 0);
        checkVal("midRst_valE", bus.valE, 0);
        rst_n = 1'b1;
        expZ = 1'b1; expS = 1'b0; expO = 1'b0;
        @(negedge clk);
        checkVal("midRst_inRdy", bus.in_ready, 1);
        checkVal("midRst_cc", {bus.cc_zf, bus.cc_sf, bus.cc_of}, 3'b100);
        checkVal("midRst_outVld2", bus.out_valid, 0);
        doOp(32'd2, 32'd3, 4'd0, 1'b1, 0, "postRstAdd");

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end
endmodule
